// File: rtl/lcd_write_ctrl.sv
// Write-only HD44780 sequencer: power-on init, then one handshaked byte at a time.
// Latency: byte latched on accept, lcdEn pulse after SETUP_CYC; backpressure: wr_ready only in IDLE.
module lcd_write_ctrl #(
    parameter int PWRON_CYC    = 750000,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic [7:0] LCD,
    output logic       lcdRS,
    output logic       lcdRW,
    output logic       lcdEn
);

    localparam int MAX_A = (PWRON_CYC > CLR_WAIT_CYC) ? PWRON_CYC : CLR_WAIT_CYC;
    localparam int MAX_B = (CMD_WAIT_CYC > PULSE_CYC) ? CMD_WAIT_CYC : PULSE_CYC;
    localparam int MAX_C = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
    localparam int MAXP  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW    = $clog2(MAXP + 1);
    localparam logic [2:0] ROM_LAST = 3'd6;

    typedef enum logic [2:0] {PWRON, INIT_LOAD, SETUP, PULSE, WAIT, IDLE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   wait_lim;
    logic [2:0]      idx;
    logic            load, load_rs, last_init, is_clr;
    logic [7:0]      load_byte;

    function automatic logic [7:0] rom(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2, 3'd3: rom = 8'h38;
            3'd4:                   rom = 8'h0C;
            3'd5:                   rom = 8'h01;
            3'd6:                   rom = 8'h06;
            default:                rom = 8'h00;
        endcase
    endfunction

    // Clear/home commands need the long execution wait.
    assign is_clr   = !lcdRS && (LCD == 8'h01 || LCD == 8'h02 || LCD == 8'h03);
    // WAIT ends one cycle early so the IDLE/INIT_LOAD cycle completes the wait.
    assign wait_lim = is_clr ? CW'(CLR_WAIT_CYC - 2) : CW'(CMD_WAIT_CYC - 2);
    assign wr_ready = (state == IDLE) && init_done;
    assign lcdRW    = 1'b0;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_byte = rom(idx);
        load_rs   = 1'b0;
        last_init = 1'b0;
        case (state)
            PWRON:     if (cnt == CW'(PWRON_CYC - 1)) state_nxt = INIT_LOAD;
            INIT_LOAD: begin
                state_nxt = SETUP;
                load      = 1'b1;
            end
            SETUP:     if (cnt == CW'(SETUP_CYC - 1)) state_nxt = PULSE;
            PULSE:     if (cnt == CW'(PULSE_CYC - 1)) state_nxt = WAIT;
            WAIT: begin
                if (cnt == wait_lim) begin
                    if (init_done) begin
                        state_nxt = IDLE;
                    end else if (idx == ROM_LAST) begin
                        state_nxt = IDLE;
                        last_init = 1'b1;
                    end else begin
                        state_nxt = INIT_LOAD;
                    end
                end
            end
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                    load_byte = wr_data;
                    load_rs   = wr_rs;
                end
            end
            default:   state_nxt = PWRON;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PWRON;
            cnt       <= '0;
            idx       <= '0;
            LCD       <= 8'h00;
            lcdRS     <= 1'b0;
            lcdEn     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + CW'(1);
            if (load) begin
                LCD   <= load_byte;
                lcdRS <= load_rs;
            end
            if (state == WAIT && state_nxt == INIT_LOAD)
                idx <= idx + 3'd1;
            if (last_init)
                init_done <= 1'b1;
            // Registered strobe keeps the enable pin glitch-free.
            lcdEn <= (state_nxt == PULSE);
        end
    end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl with shortened timing parameters.
module tb_lcd_write_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       init_done;
    logic [7:0] LCD;
    logic       lcdRS;
    logic       lcdRW;
    logic       lcdEn;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_start = 0;
    logic en_prev = 1'b0;

    int         rise_cyc[$];
    logic [7:0] rise_byte[$];
    logic       rise_rs[$];
    int         width_q[$];

    lcd_write_ctrl #(
        .PWRON_CYC(20), .SETUP_CYC(2), .PULSE_CYC(4),
        .CMD_WAIT_CYC(10), .CLR_WAIT_CYC(30)
    ) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done),
        .LCD(LCD), .lcdRS(lcdRS), .lcdRW(lcdRW), .lcdEn(lcdEn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (lcdEn && !en_prev) begin
            rise_cyc.push_back(cyc);
            rise_byte.push_back(LCD);
            rise_rs.push_back(lcdRS);
            en_start = cyc;
        end
        if (!lcdEn && en_prev) width_q.push_back(cyc - en_start);
        en_prev = lcdEn;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        en_prev = lcdEn;
        rise_cyc.delete();
        rise_byte.delete();
        rise_rs.delete();
        width_q.delete();
    endtask

    // Runs from reset release to the end of init and checks all seven pulses.
    task automatic run_init(input string pfx);
        int         exp_rise[7];
        logic [7:0] exp_byte[7];
        exp_rise = '{23, 39, 55, 71, 87, 103, 139};
        exp_byte = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        repeat (151) step();
        chk({pfx, " ready_151"}, 32'(wr_ready), 32'd0);
        chk({pfx, " done_151"}, 32'(init_done), 32'd0);
        step();
        chk({pfx, " ready_152"}, 32'(wr_ready), 32'd1);
        chk({pfx, " done_152"}, 32'(init_done), 32'd1);
        chk({pfx, " pulses"}, 32'(rise_cyc.size()), 32'd7);
        chk({pfx, " widths"}, 32'(width_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < rise_cyc.size(); i++) begin
            chk($sformatf("%s rise%0d_cyc", pfx, i), 32'(rise_cyc[i]), 32'(exp_rise[i]));
            chk($sformatf("%s rise%0d_byte", pfx, i), 32'(rise_byte[i]), 32'(exp_byte[i]));
            chk($sformatf("%s rise%0d_rs", pfx, i), 32'(rise_rs[i]), 32'd0);
        end
        for (int i = 0; i < 7 && i < width_q.size(); i++)
            chk($sformatf("%s width%0d", pfx, i), 32'(width_q[i]), 32'd4);
    endtask

    // One accepted byte; rdy_at is the edge whose sample sees wr_ready again.
    task automatic send(input string pfx, input logic rs, input logic [7:0] d, input int rdy_at);
        logic [10:0] exp_v;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        wr_rs    = ~rs;
        wr_data  = ~d;
        chk({pfx, " accept"}, 32'({wr_ready, lcdRS, LCD}), 32'({1'b0, rs, d}));
        for (int k = 1; k < rdy_at; k++) begin
            step();
            exp_v = {(k >= 2 && k < 6), (k == rdy_at - 1), rs, d};
            chk($sformatf("%s T+%0d", pfx, k), 32'({lcdEn, wr_ready, lcdRS, LCD}), 32'(exp_v));
        end
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst LCD", 32'(LCD), 32'h00);
        chk("rst RS", 32'(lcdRS), 32'd0);
        chk("rst RW", 32'(lcdRW), 32'd0);
        chk("rst En", 32'(lcdEn), 32'd0);
        chk("rst ready", 32'(wr_ready), 32'd0);
        chk("rst done", 32'(init_done), 32'd0);
        release_reset();
        run_init("init1");

        send("data41", 1'b1, 8'h41, 16);
        send("cmd01", 1'b0, 8'h01, 36);
        send("data01", 1'b1, 8'h01, 16);

        // Back-to-back with wr_valid held.
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h48;
        step();
        chk("b2b first", 32'({wr_ready, LCD}), 32'({1'b0, 8'h48}));
        for (int k = 1; k <= 15; k++) begin
            step();
            chk($sformatf("b2b T+%0d", k), 32'({lcdEn, wr_ready, LCD}),
                32'({(k >= 2 && k < 6), (k == 15), 8'h48}));
        end
        wr_data = 8'h49;
        step();
        chk("b2b accept16", 32'({wr_ready, lcdRS, LCD}), 32'({1'b0, 1'b1, 8'h49}));
        wr_valid = 1'b0;
        step();
        chk("b2b en17", 32'(lcdEn), 32'd0);
        step();
        chk("b2b en18", 32'(lcdEn), 32'd1);
        repeat (13) step();
        chk("b2b ready_again", 32'(wr_ready), 32'd1);

        // Reset while the enable strobe is high.
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h77;
        step();
        wr_valid = 1'b0;
        repeat (2) step();
        chk("midrst en_high", 32'(lcdEn), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst outputs", 32'({lcdEn, LCD, lcdRS, wr_ready, init_done}), 32'd0);

        // Request held throughout init must wait for the first wr_ready.
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h55;
        release_reset();
        run_init("init2");
        chk("hold55 not_early", 32'(LCD), 32'h06);
        step();
        chk("hold55 accept", 32'({wr_ready, lcdRS, LCD}), 32'({1'b0, 1'b1, 8'h55}));
        wr_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
